// File: rtl/apb_regr_ctrl.sv
// apb_regr_ctrl -- APB slave exposing REGRN read-only registers with a
// programmable number of wait states.
//
// Transfer flow: IDLE -> WAIT (WAIT_CYC-1 extra edges) -> RESP -> IDLE.
// A setup phase sampled in IDLE starts a transfer. With WAIT_CYC=0 the FSM
// jumps straight to RESP on that edge. PREADY, PRDATA and PSLVERR are non-zero
// only in RESP. All outputs come directly from flops.
//
// Optional feature: define APB_SLVERR_EN to raise PSLVERR together with PREADY
// for writes and for out-of-range reads. When it is not defined, PSLVERR stays
// 0 and these transfers finish silently with PRDATA=0.
//
// Ports
//   PCLK, PRESETn           clock; asynchronous active-low reset
//   PSEL, PENABLE, PWRITE   APB control
//   PADDR   [AWIDTH]        register word index
//   regr_in [REGRN*DWIDTH]  register sources; slice i = [i*DWIDTH +: DWIDTH]
//   PRDATA  [DWIDTH]        read data (valid in RESP)
//   PREADY, PSLVERR         completion / error response
//   pselr   [REGRN]         one-hot select of the register being read
//   busy                    high whenever the FSM is not in IDLE
module apb_regr_ctrl #(
  parameter int DWIDTH   = 8,
  parameter int REGRN    = 3,
  parameter int AWIDTH   = 4,
  parameter int WAIT_CYC = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [REGRN*DWIDTH-1:0] regr_in,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [REGRN-1:0]        pselr,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0]      WAIT_C  = 4'(WAIT_CYC);
  localparam logic [AWIDTH:0] REGRN_W = (AWIDTH+1)'(REGRN);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DWIDTH-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [REGRN-1:0]    pselr_q, pselr_d;
  logic                busy_q, busy_d;

  // Decode the transfer in progress. In IDLE this is the live bus, because a
  // zero-wait transfer must select and sample on the setup edge itself.
  // After that edge the latched copy is used.
  logic [AWIDTH-1:0]   cur_addr;
  logic                cur_write, rd_ok, slverr_resp;
  logic [DWIDTH-1:0]   rd_data;
  logic [REGRN-1:0]    rd_sel;

  always_comb begin
    cur_addr  = (state_q == S_IDLE) ? PADDR  : addr_q;
    cur_write = (state_q == S_IDLE) ? PWRITE : write_q;
    rd_ok     = !cur_write && ({1'b0, cur_addr} < REGRN_W);
    rd_data   = '0;
    rd_sel    = '0;
    for (int i = 0; i < REGRN; i++) begin
      if (rd_ok && cur_addr == AWIDTH'(i)) begin
        rd_data   = regr_in[i*DWIDTH +: DWIDTH];
        rd_sel[i] = 1'b1;
      end
    end
  end

`ifdef APB_SLVERR_EN
  assign slverr_resp = !rd_ok;
`else
  assign slverr_resp = 1'b0;
`endif

  logic clr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    pselr_d   = pselr_q;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          cnt_d   = WAIT_C;
          pselr_d = rd_sel;
          if (WAIT_CYC == 0) begin
            state_d   = S_RESP;
            prdata_d  = rd_data;
            pready_d  = 1'b1;
            pslverr_d = slverr_resp;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          clr = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          // regr_in is captured here, so changes made during WAIT are visible.
          state_d   = S_RESP;
          cnt_d     = 4'd0;
          prdata_d  = rd_data;
          pready_d  = 1'b1;
          pslverr_d = slverr_resp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // PRDATA stays frozen while the FSM waits for the access phase.
        if (!PSEL || (PENABLE && pready_q)) clr = 1'b1;
      end
      default: clr = 1'b1;
    endcase
    if (clr) begin
      state_d   = S_IDLE;
      cnt_d     = 4'd0;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      pselr_d   = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      pselr_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      pselr_q   <= pselr_d;
      busy_q    <= busy_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign pselr   = pselr_q;
  assign busy    = busy_q;

endmodule

// File: doc/apb_regr_ctrl.md
APB_REGR_CTRL -- requirements
Module: apb_regr_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: register data width.
REQ-002 SHALL have parameter REGRN, default 3: number of read registers, max 2**AWIDTH.
REQ-003 SHALL have parameter AWIDTH, default 4: PADDR width (word index).
REQ-004 SHALL have parameter WAIT_CYC, default 1: wait states inserted before PREADY, range 0..15.
REQ-005 SHALL have port PCLK, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port PRESETn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports PSEL, PENABLE, PWRITE, input, 1 each: APB control.
REQ-008 SHALL have port PADDR, input, AWIDTH: register index.
REQ-009 SHALL have port regr_in, input, REGRN*DWIDTH: register sources; slice i = bits [i*DWIDTH +: DWIDTH].
REQ-010 SHALL have port PRDATA, output, DWIDTH: read data.
REQ-011 SHALL have port PREADY, output, 1: transfer completion.
REQ-012 SHALL have port PSLVERR, output, 1: error response.
REQ-013 SHALL have port pselr, output, REGRN: one-hot register select.
REQ-014 SHALL have port busy, output, 1: high in any state except IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-016 IDLE: on an edge sampling PSEL=1, PENABLE=0: latch PADDR/PWRITE, load wait counter with WAIT_CYC, go to WAIT (RESP directly if WAIT_CYC=0).
REQ-017 WAIT: counter decrements each edge; at count 1 go to RESP; PREADY=0 throughout.
REQ-018 Valid read (PWRITE=0, PADDR<REGRN): pselr[PADDR]=1 from the edge leaving IDLE until the edge leaving RESP; all other pselr bits 0.
REQ-019 Entering RESP: PRDATA <= regr_in slice[PADDR] sampled at that edge; PREADY <= 1.
REQ-020 PREADY SHALL rise WAIT_CYC+1 edges after the setup-sampling edge.
REQ-021 RESP: the edge sampling PSEL=1, PENABLE=1, PREADY=1 completes the transfer -> IDLE; PREADY, PSLVERR, pselr, PRDATA cleared to 0 on that edge.
REQ-022 PSEL=0 sampled in WAIT or RESP (aborted transfer) -> IDLE, all outputs cleared, no error flagged.
REQ-023 Out-of-range read (PADDR>=REGRN) or any write: pselr stays all-zero, PRDATA=0 in RESP, same timing as a valid read.
REQ-024 A setup phase immediately after completion is accepted from IDLE on the next edge (back-to-back = one idle cycle minimum).
REQ-025 regr_in changes during WAIT SHALL be reflected; changes after entering RESP SHALL NOT alter PRDATA.
REQ-026 Outside RESP: PRDATA=0, PREADY=0, PSLVERR=0.

Reset
REQ-027 PRESETn=0 SHALL immediately force state IDLE, counter 0, PRDATA=0, PREADY=0, PSLVERR=0, pselr=0, busy=0.
REQ-028 Reset mid-transfer SHALL discard it; the first setup phase after PRESETn rises is accepted normally.

Configuration
REQ-029 With APB_SLVERR_EN defined: PSLVERR=1 with PREADY in RESP for out-of-range reads and all writes.
REQ-030 Without APB_SLVERR_EN: PSLVERR tied to 0; such transfers complete silently with PRDATA=0.

Verification (DWIDTH=8, REGRN=3, WAIT_CYC=1)
REQ-031 Read PADDR=1, regr_in=0x33_22_11 -> pselr=3'b010, PREADY high 2 edges after setup, PRDATA=0x22, PSLVERR=0.
REQ-032 Read PADDR=5 with APB_SLVERR_EN -> pselr=0, PRDATA=0x00, PSLVERR=1 with PREADY; without macro -> PSLVERR=0.
REQ-033 Back-to-back reads PADDR=0 then 2 -> PRDATA 0x11 then 0x33, one IDLE cycle between, pselr 001 then 100.
REQ-034 Drop PSEL during WAIT -> state IDLE next edge, pselr=0, PREADY never asserted.
REQ-035 Assert PRESETn=0 in RESP -> PREADY/pselr/PRDATA 0 without waiting for PCLK; next read PADDR=2 returns 0x33.
REQ-036 WAIT_CYC=0, read PADDR=0 -> PREADY high 1 edge after setup, PRDATA=0x11.
